// File: rtl/blink_gen.sv
// Multi-channel LED pattern generator: one shared tick prescaler plus independent
// per-channel OFF / ON / BLINK / BURST sequencers, all outputs registered.
module blink_gen #(
    parameter int CLK_HZ   = 12_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CH       = 4,
    parameter int PW       = 16,
    parameter int BURST_N  = 3,
    parameter int GAP_MULT = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [2*CH-1:0] MODE,
    input  logic [PW*CH-1:0] HALF,
    output logic            TICK,
    output logic [CH-1:0]   OUT
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PHW = PW + $clog2(GAP_MULT) + 1;
    localparam int FW  = $clog2(BURST_N + 1);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_ON    = 2'b01,
        M_BLINK = 2'b10,
        M_BURST = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        FLASH_ON  = 2'b00,
        FLASH_OFF = 2'b01,
        GAP       = 2'b10
    } bstate_t;

    logic [CW-1:0] pre_cnt;
    logic          adv;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt <= '0;
            TICK    <= 1'b0;
        end else if (CE) begin
            if (pre_cnt == CW'(DIV - 1)) begin
                pre_cnt <= '0;
                TICK    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + CW'(1);
                TICK    <= 1'b0;
            end
        end else begin
            TICK <= 1'b0;
        end
    end

    // Channels advance only while counting is enabled, so CE low freezes them too.
    assign adv = TICK & CE;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        mode_t          mode_in, mode_q, mode_d;
        bstate_t        st_q, st_d;
        logic [PHW-1:0] ph_q, ph_d, lim;
        logic [FW-1:0]  fl_q, fl_d;
        logic [PW-1:0]  h_q, h_d, h_eff;
        logic           out_q, out_d;

        assign mode_in = mode_t'(MODE[2*i +: 2]);
        assign h_eff   = (HALF[PW*i +: PW] == '0) ? PW'(1) : HALF[PW*i +: PW];

        // h_q holds the half-period latched at the last phase reload; lim is the last count of the segment.
        always_comb begin
            if (mode_q == M_BURST && st_q == GAP)
                lim = PHW'(GAP_MULT) * PHW'(h_q) - PHW'(1);
            else
                lim = PHW'(h_q) - PHW'(1);
        end

        // NOTE: every output of this block is defaulted first so no latch can be inferred.
        always_comb begin
            mode_d = mode_q;
            st_d   = st_q;
            ph_d   = ph_q;
            fl_d   = fl_q;
            h_d    = h_q;
            out_d  = out_q;
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                st_d   = FLASH_ON;
                ph_d   = '0;
                fl_d   = '0;
                h_d    = h_eff;
                out_d  = (mode_in != M_OFF);
            end else if (adv) begin
                unique case (mode_q)
                    M_BLINK: begin
                        if (ph_q == lim) begin
                            ph_d  = '0;
                            h_d   = h_eff;
                            out_d = ~out_q;
                        end else begin
                            ph_d = ph_q + PHW'(1);
                        end
                    end
                    M_BURST: begin
                        if (ph_q == lim) begin
                            ph_d = '0;
                            h_d  = h_eff;
                            unique case (st_q)
                                FLASH_ON: begin
                                    st_d  = FLASH_OFF;
                                    out_d = 1'b0;
                                    fl_d  = fl_q + FW'(1);
                                end
                                FLASH_OFF: begin
                                    if (fl_q == FW'(BURST_N)) begin
                                        st_d  = GAP;
                                        fl_d  = '0;
                                        out_d = 1'b0;
                                    end else begin
                                        st_d  = FLASH_ON;
                                        out_d = 1'b1;
                                    end
                                end
                                GAP: begin
                                    st_d  = FLASH_ON;
                                    out_d = 1'b1;
                                end
                                default: begin
                                    st_d  = FLASH_ON;
                                    out_d = 1'b1;
                                end
                            endcase
                        end else begin
                            ph_d = ph_q + PHW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                mode_q <= M_OFF;
                st_q   <= FLASH_ON;
                ph_q   <= '0;
                fl_q   <= '0;
                h_q    <= PW'(1);
                out_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                st_q   <= st_d;
                ph_q   <= ph_d;
                fl_q   <= fl_d;
                h_q    <= h_d;
                out_q  <= out_d;
            end
        end

        assign OUT[i] = out_q;
    end

endmodule

// File: tb/tb_blink_gen.sv
// Bench for blink_gen: directed scenarios plus random traffic, every cycle compared
// against a segment-list reference model of the LED patterns.
module tb_blink_gen;

    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int CH       = 4;
    localparam int PW       = 8;
    localparam int BURST_N  = 3;
    localparam int GAP_MULT = 4;

    localparam logic [1:0] OFF = 2'b00, ON = 2'b01, BLINK = 2'b10, BURST = 2'b11;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CE;
    logic [2*CH-1:0]  MODE;
    logic [PW*CH-1:0] HALF;
    logic             TICK;
    logic [CH-1:0]    OUT;

    int total = 0;
    int bad   = 0;

    // Reference model: tick = every DIV-th enabled cycle; each pattern is a list of segments with deadlines.
    int            ce_cnt = 0;
    logic          m_tick = 1'b0;
    logic [CH-1:0] m_out  = '0;
    int            m_mode [CH];
    int            m_n    [CH];
    int            m_seg  [CH];
    int            m_end  [CH];

    blink_gen #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(CH), .PW(PW),
        .BURST_N(BURST_N), .GAP_MULT(GAP_MULT)
    ) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .HALF(HALF),
        .TICK(TICK), .OUT(OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s at t=%0t: got %0d (0x%0h) expected %0d (0x%0h)", tag, $time, got, got, exp, exp);
        end
    endtask

    function automatic int eff_h(input int ch);
        int h;
        h = int'(HALF[PW*ch +: PW]);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int n_segs(input int md);
        return (md == 3) ? 2 * BURST_N + 1 : 2;
    endfunction

    function automatic int seg_len(input int md, input int seg, input int h);
        return (md == 3 && seg == 2 * BURST_N) ? GAP_MULT * h : h;
    endfunction

    function automatic logic seg_level(input int md, input int seg);
        if (md == 3 && seg == 2 * BURST_N) return 1'b0;
        return (seg % 2) == 0;
    endfunction

    task automatic model_edge();
        logic t_in;
        int   md;
        t_in = m_tick && CE;
        if (RST) begin
            ce_cnt = 0;
            m_tick = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = 0;
                m_out[c]  = 1'b0;
                m_n[c]    = 0;
                m_seg[c]  = 0;
                m_end[c]  = 0;
            end
        end else begin
            if (CE) begin
                ce_cnt++;
                m_tick = (ce_cnt % DIV) == 0;
            end else begin
                m_tick = 1'b0;
            end
            for (int c = 0; c < CH; c++) begin
                md = int'(MODE[2*c +: 2]);
                if (md != m_mode[c]) begin
                    m_mode[c] = md;
                    m_n[c]    = 0;
                    m_seg[c]  = 0;
                    m_end[c]  = seg_len(md, 0, eff_h(c));
                    m_out[c]  = (md != 0);
                end else if (t_in && md >= 2) begin
                    m_n[c]++;
                    if (m_n[c] == m_end[c]) begin
                        m_seg[c] = (m_seg[c] + 1) % n_segs(md);
                        m_end[c] = m_n[c] + seg_len(md, m_seg[c], eff_h(c));
                        m_out[c] = seg_level(md, m_seg[c]);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("tick_vs_model", 32'(TICK), 32'(m_tick));
        check("out_vs_model", 32'(OUT), 32'(m_out));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic measure_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (TICK !== 1'b1 && n < 300);
    endtask

    task automatic measure_edge(input int ch, output int n);
        logic prev;
        prev = OUT[ch];
        n = 0;
        do begin
            step();
            n++;
        end while (OUT[ch] === prev && n < 300);
    endtask

    initial begin
        int n;
        int found;
        int sum;
        int viol;
        int exp_iv [6];

        RST  = 1'b1;
        CE   = 1'b0;
        MODE = '0;
        HALF = '0;
        run(3);
        check("rst_tick", 32'(TICK), 0);
        check("rst_out", 32'(OUT), 0);

        // Prescaler period and CE hold.
        RST = 1'b0;
        CE  = 1'b1;
        measure_tick(n);
        check("first_tick", n, DIV);
        measure_tick(n);
        check("tick_period", n, DIV);
        run(3);
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("no_tick_ce_low", 32'(TICK), 0);
        end
        CE = 1'b1;
        measure_tick(n);
        check("tick_ce_gap", 3 + 5 + n, DIV + 5);

        // BLINK on channel 0, then a mid-phase HALF change.
        MODE[1:0] = BLINK;
        HALF[7:0] = 8'd3;
        step();
        check("blink_start", 32'(OUT[0]), 1);
        measure_edge(0, n);
        measure_edge(0, n);
        check("blink_half_a", n, 3 * DIV);
        measure_edge(0, n);
        check("blink_half_b", n, 3 * DIV);
        run(5);
        HALF[7:0] = 8'd1;
        measure_edge(0, n);
        check("blink_phase_done", 5 + n, 3 * DIV);
        measure_edge(0, n);
        check("blink_new_half", n, DIV);
        MODE[1:0] = OFF;
        step();
        check("off_out", 32'(OUT[0]), 0);

        // BURST on channel 1 with H=2.
        MODE[3:2]  = BURST;
        HALF[15:8] = 8'd2;
        step();
        check("burst_start", 32'(OUT[1]), 1);
        measure_edge(1, n);
        exp_iv = '{2*DIV, 2*DIV, 2*DIV, 2*DIV, (1 + GAP_MULT)*2*DIV, 2*DIV};
        sum = 0;
        for (int k = 0; k < 6; k++) begin
            measure_edge(1, n);
            check("burst_segment", n, exp_iv[k]);
            sum += n;
        end
        check("burst_period", sum, (2*BURST_N + GAP_MULT)*2*DIV);

        // HALF=0 behaves as 1.
        MODE[5:4]   = BLINK;
        HALF[23:16] = 8'd0;
        step();
        measure_edge(2, n);
        measure_edge(2, n);
        check("half0_a", n, DIV);
        measure_edge(2, n);
        check("half0_b", n, DIV);

        // BLINK->ON on the very edge a tick would have toggled OUT[2] low.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            measure_tick(n);
            if (OUT[2] === 1'b1) found = 1;
        end
        check("tick_sync_blink", found, 1);
        MODE[5:4] = ON;
        step();
        check("mode_over_tick", 32'(OUT[2]), 1);
        run(25);
        check("on_hold", 32'(OUT[2]), 1);

        // Reset mid-burst, coinciding with a tick.
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            measure_tick(n);
            if (OUT[1] === 1'b1) found = 1;
        end
        check("tick_sync_burst", found, 1);
        RST = 1'b1;
        step();
        check("rst_mid_out", 32'(OUT), 0);
        check("rst_mid_tick", 32'(TICK), 0);

        // Independence: ch3 BURST H=2, ch2 BLINK H=3, ch1 OFF, ch0 ON.
        MODE = {BURST, BLINK, OFF, ON};
        HALF = {8'd2, 8'd3, 8'd0, 8'd0};
        step();
        RST = 1'b0;
        step();
        check("rst_release_on", 32'(OUT[0]), 1);
        viol = 0;
        for (int i = 0; i < 420; i++) begin
            step();
            if (OUT[0] !== 1'b1 || OUT[1] !== 1'b0) viol++;
        end
        check("indep_const", viol, 0);

        // Random traffic against the model.
        for (int k = 0; k < 25; k++) begin
            int len;
            len  = $urandom_range(20, 80);
            MODE = 8'($urandom);
            for (int c = 0; c < CH; c++) HALF[PW*c +: PW] = 8'($urandom_range(0, 3));
            RST = ($urandom_range(0, 19) == 0);
            for (int j = 0; j < len; j++) begin
                CE = ($urandom_range(0, 7) != 0);
                if (j == len / 2) HALF[PW*(k % CH) +: PW] = 8'($urandom_range(0, 3));
                step();
                RST = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blink_gen.md
Name: blink_gen

Overview:
- Multi-channel LED pattern generator; parametrised successor to the single fixed-rate toggle counter used on the board LEDs.
- One shared prescaler derives a TICK_HZ timebase from CLK.
- Each channel independently drives one output in OFF, ON, BLINK or BURST mode, with a per-channel half-period counted in ticks.
- Sits between top-level control logic (switches/status) and the LED pins.

Parameters:
- CLK_HZ, 12_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, timebase rate. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
- CH, 4, number of channels.
- PW, 16, width of each per-channel half-period field, in ticks.
- BURST_N, 3, flashes per burst (>= 1).
- GAP_MULT, 4, burst gap length in units of half-period (>= 1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- CE  in  1  count enable. When low, the prescaler holds, no TICK is issued, and all channels freeze.
- MODE  in  2*CH  per-channel mode; channel i uses [2i+1:2i]. 00 OFF, 01 ON, 10 BLINK, 11 BURST.
- HALF  in  PW*CH  per-channel half-period in ticks; channel i uses [PW*i+PW-1:PW*i]. The value 0 is treated as 1.
- TICK  out  1  one-CLK pulse per timebase period (registered).
- OUT  out  CH  channel outputs (registered).

Behaviour:
- Reset (RST=1 at an edge):
  - prescaler count = 0, TICK = 0, OUT = 0.
  - All phase counters = 0, all flash counters = 0.
  - Stored mode per channel = OFF, burst state = FLASH_ON.
  - RST has priority over CE and MODE.
  - Reset mid-burst or mid-phase: OUT = 0 after that same edge.
- Prescaler:
  - Counter runs 0..DIV-1, advancing only when CE=1.
  - When count == DIV-1 and CE=1: the count wraps to 0 and TICK=1 for the following cycle.
  - The wrap is also gated by CE; the count never passes DIV-1.
- Effective half-period: H = (HALF_i == 0) ? 1 : HALF_i. HALF is sampled at each phase reload, so a change takes effect at the next phase boundary, not mid-phase.
- Mode change: if MODE_i differs from the stored mode at an edge (CE is irrelevant), the channel restarts on that edge:
  - the stored mode updates;
  - phase counter = 0, flash counter = 0, burst state = FLASH_ON;
  - OUT_i = 0 for OFF, 1 for ON/BLINK/BURST.
  - A simultaneous tick is ignored for that channel.
  - Consequence: after RST deasserts with MODE_i=ON, OUT_i=1 one edge later.
- OFF / ON: OUT_i is held at 0 / 1; the phase counter stays idle.
- BLINK: on each tick, phase counter +1. When the phase counter reaches H-1 on a tick: phase counter = 0 and OUT_i toggles. The square wave period is 2*H ticks.
- BURST: a three-state machine with transitions on ticks only. The phase counter is PW+clog2(GAP_MULT)+1 bits wide, so no overflow.
  - FLASH_ON (OUT=1): after H ticks, go to FLASH_OFF with OUT=0 and flash counter +1.
  - FLASH_OFF (OUT=0): after H ticks:
    - if flash counter == BURST_N, go to GAP and clear the flash counter;
    - otherwise go to FLASH_ON with OUT=1.
  - GAP (OUT=0): after GAP_MULT*H ticks, go to FLASH_ON with OUT=1.
  - Pattern period = (2*BURST_N + GAP_MULT)*H ticks.
- Channels are fully independent and share only TICK.
- Latency: an OUT edge appears on the CLK edge at which the TICK pulse is high, i.e. one cycle after the prescaler wrap.

Test Plan:
- Bench uses CLK_HZ=100, TICK_HZ=10 (DIV=10), CH=4, PW=8, BURST_N=3, GAP_MULT=4.
- Prescaler: CE=1 -> TICK high exactly 1 cycle in every 10. CE low for 5 cycles mid-count -> next TICK arrives 15 cycles after the previous one; no TICK while CE=0.
- BLINK: MODE0=10, HALF0=3 -> OUT[0] goes 1 one edge after the mode write, then toggles every 30 CLK (period 60). HALF0 changed to 1 mid-phase -> the current phase completes at 3 ticks, later phases are 1 tick.
- BURST: MODE1=11, HALF1=2 -> OUT[1] shows 3 pulses of 20 CLK high / 20 CLK low, then 80 CLK low; pattern repeats every 200 CLK.
- Edge cases:
  - HALF2=0 in BLINK -> toggles every 10 CLK, same as HALF=1.
  - MODE change BLINK->ON in the same cycle as TICK -> OUT=1 on the next edge; the tick has no effect.
  - RST asserted mid-burst -> OUT=0 and TICK=0 after that edge.
  - RST released with MODE=ON -> OUT=1 one edge later.
- Independence: MODE = {BURST, BLINK, OFF, ON} on channels 3..0 -> OUT[0]=1 constant and OUT[1]=0 constant; OUT[2] and OUT[3] match the single-channel runs above, cycle for cycle.
